gamepad_ctrl: RTL and testbench
===============================

# gamepad_ctrl

Sequencing controller between the simulated gamepad and the two-channel blink datapath. Debounces the six gamepad keys, turns presses into one-cycle events, and runs a mode FSM that drives the two LED-channel enables and a programmable alternation period. Sits where the gamepad A/B keys currently wire straight to the blinker enables.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable samples before a key level is accepted (≥1)
- PERIOD_W, 8: width of the period register/counter
- PERIOD_MIN, 2: lower saturation bound of period_o (≥1)
- PERIOD_MAX, 200: upper saturation bound (< 2**PERIOD_W)
- PERIOD_DEF, 20: period after reset or B press
- PERIOD_STEP, 2: increment/decrement per up/down press
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- key_up_i, key_down_i, key_left_i, key_right_i, key_a_i, key_b_i  in  1 each  raw key levels, 1 = pressed
- en1_o  out  1  LED channel 1 enable
- en2_o  out  1  LED channel 2 enable
- period_o  out  PERIOD_W  current alternation period in cycles
- mode_o  out  3  current mode encoding (OFF=0, CH1=1, CH2=2, BOTH=3, ALT=4)
- paused_o  out  1  pause flag

## Operation
- Debounce per key: accepted level register plus counter. Raw ≠ accepted → count++; raw = accepted → count cleared. Count reaching DEBOUNCE_CYCLES → accepted := raw, count cleared. Press event = accepted rising edge, a one-cycle pulse. Releases generate no event.
- Mode FSM states: OFF, CH1, CH2, BOTH, ALT.
  - right: OFF→CH1→CH2→BOTH→ALT→OFF.
  - left: the reverse order. OFF→ALT wraps.
- Event priority within one cycle: B > A > (left/right). B: mode := OFF, period := PERIOD_DEF, pause := 0. A: toggle pause; mode unchanged. left and right together: no mode change.
- up/down: period ± PERIOD_STEP, saturating at PERIOD_MAX/PERIOD_MIN. up and down together: no change. Processed independently of mode events; B overrides them.
- Output decode:
  - paused or OFF → en1=0, en2=0
  - CH1 → 1/0; CH2 → 0/1; BOTH → 1/1
  - ALT → en1 = ~phase, en2 = phase
- ALT timer: counter runs only in ALT and not paused. When counter ≥ period_o−1: counter := 0, phase toggles; otherwise counter++.
  - Entering ALT from any state clears counter and phase.
  - Pause freezes both; resume continues from the frozen values.
  - A period decrease below the current count wraps on the next edge.

## Timing
- Reset values:
  - en1_o=0, en2_o=0, mode_o=0 (OFF), period_o=PERIOD_DEF, paused_o=0
  - all accepted levels, debounce counters, ALT counter and phase = 0
- Key latency: raw held high from before edge 1 → accepted at edge DEBOUNCE_CYCLES → mode/period/pause update at edge DEBOUNCE_CYCLES+1. Outputs are combinational decode of registers, so they are valid after that edge.
- A glitch shorter than DEBOUNCE_CYCLES samples produces no event.
- ALT: each phase lasts exactly period_o cycles at constant period.
- Reset mid-operation clears everything, including debounce state. A key held across reset release produces a press DEBOUNCE_CYCLES+1 edges after release.

## Structure
- gamepad_ctrl_pkg: mode_e enum (3-bit, encodings above), mode next/prev functions, default parameter constants.
- Sub-module key_debounce (DEBOUNCE_CYCLES param; ports clk_i, rst_i, key_i, level_o, press_o), instantiated six times.
- Top holds the FSM, pause flag, period register and ALT timer.

## Test plan
- Reset with all keys low → en=0/0, mode_o=0, period_o=20, paused_o=0. Hold right high: mode_o=1 exactly 5 edges after the first sampled high, en=1/0.
- right pulse lasting 3 cycles (DEBOUNCE_CYCLES=4) → no mode change. Five debounced right presses → modes 1,2,3,4,0. One left press from OFF → mode 4.
- ALT with period 20 → en1 high 20 cycles, then en2 high 20 cycles, repeating. Press A mid-phase → en=0/0 and counter frozen. Press A again → the phase completes its remaining cycles.
- 100 up presses → period_o saturates at 200. 100 down presses → saturates at 2. up+down pressed together → period unchanged.
- A+B+right released from debounce in the same cycle → mode OFF, paused_o=0, period_o=20.
- Reset asserted for one cycle in ALT while paused → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/gamepad_ctrl_pkg.sv
// Shared types and defaults for the gamepad sequencing controller.
// Mode encoding and mode stepping helpers live here.
package gamepad_ctrl_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_PERIOD_W        = 8;
    localparam int DEF_PERIOD_MIN      = 2;
    localparam int DEF_PERIOD_MAX      = 200;
    localparam int DEF_PERIOD_DEF      = 20;
    localparam int DEF_PERIOD_STEP     = 2;

    typedef enum logic [2:0] {
        MODE_OFF  = 3'd0,
        MODE_CH1  = 3'd1,
        MODE_CH2  = 3'd2,
        MODE_BOTH = 3'd3,
        MODE_ALT  = 3'd4
    } mode_e;

    // Forward step through the mode ring (right key).
    function automatic mode_e mode_next(input mode_e m);
        mode_e r;
        case (m)
            MODE_OFF:  r = MODE_CH1;
            MODE_CH1:  r = MODE_CH2;
            MODE_CH2:  r = MODE_BOTH;
            MODE_BOTH: r = MODE_ALT;
            default:   r = MODE_OFF;
        endcase
        return r;
    endfunction

    // Backward step through the mode ring (left key).
    function automatic mode_e mode_prev(input mode_e m);
        mode_e r;
        case (m)
            MODE_CH1:  r = MODE_OFF;
            MODE_CH2:  r = MODE_CH1;
            MODE_BOTH: r = MODE_CH2;
            MODE_ALT:  r = MODE_BOTH;
            default:   r = MODE_ALT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gamepad_ctrl_debounce.sv
// Single-key debouncer: accepts a new level after DEBOUNCE_CYCLES
// consecutive differing samples; press_o pulses on accepted rise.
module key_debounce
    import gamepad_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_d;

    // Count disagreeing samples; flip accepted level once the run is long enough.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (key_i == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_level <= key_i;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Delayed copy of the accepted level for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_level_d <= 1'b0;
        else       r_level_d <= r_level;
    end

    assign level_o = r_level;
    assign press_o = r_level & ~r_level_d;

endmodule

// File: rtl/gamepad_ctrl.sv
// Gamepad sequencing controller: debounced key events drive the mode
// FSM, pause flag, alternation period and ALT phase timer.
module gamepad_ctrl
    import gamepad_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PERIOD_W        = DEF_PERIOD_W,
    parameter int PERIOD_MIN      = DEF_PERIOD_MIN,
    parameter int PERIOD_MAX      = DEF_PERIOD_MAX,
    parameter int PERIOD_DEF      = DEF_PERIOD_DEF,
    parameter int PERIOD_STEP     = DEF_PERIOD_STEP
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                key_up_i,
    input  logic                key_down_i,
    input  logic                key_left_i,
    input  logic                key_right_i,
    input  logic                key_a_i,
    input  logic                key_b_i,
    output logic                en1_o,
    output logic                en2_o,
    output logic [PERIOD_W-1:0] period_o,
    output logic [2:0]          mode_o,
    output logic                paused_o
);

    localparam int K_UP    = 0;
    localparam int K_DOWN  = 1;
    localparam int K_LEFT  = 2;
    localparam int K_RIGHT = 3;
    localparam int K_A     = 4;
    localparam int K_B     = 5;

    localparam logic [PERIOD_W:0]   P_MAX  = (PERIOD_W+1)'(PERIOD_MAX);
    localparam logic [PERIOD_W:0]   P_MIN  = (PERIOD_W+1)'(PERIOD_MIN);
    localparam logic [PERIOD_W:0]   P_STEP = (PERIOD_W+1)'(PERIOD_STEP);
    localparam logic [PERIOD_W-1:0] P_DEF  = PERIOD_W'(PERIOD_DEF);

    logic [5:0]          w_keys;
    logic [5:0]          w_level;
    logic [5:0]          w_press;
    logic [5:0]          w_ev;

    mode_e               r_mode;
    logic                r_paused;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_alt_cnt;
    logic                r_phase;

    mode_e               w_mode_nx;
    logic                w_paused_nx;
    logic [PERIOD_W-1:0] w_period_nx;
    logic [PERIOD_W:0]   w_sum_up;
    logic [PERIOD_W-1:0] w_per_up;
    logic [PERIOD_W-1:0] w_per_dn;
    logic                w_alt_wrap;
    logic                w_enter_alt;

    assign w_keys = {key_b_i, key_a_i, key_right_i,
                     key_left_i, key_down_i, key_up_i};

    genvar g;
    generate
        for (g = 0; g < 6; g++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .key_i  (w_keys[g]),
                .level_o(w_level[g]),
                .press_o(w_press[g])
            );
        end
    endgenerate

    assign w_ev = w_press & w_level;

    assign w_sum_up = {1'b0, r_period} + P_STEP;
    assign w_per_up = (w_sum_up > P_MAX) ? P_MAX[PERIOD_W-1:0]
                                         : w_sum_up[PERIOD_W-1:0];
    assign w_per_dn = ({1'b0, r_period} < (P_MIN + P_STEP))
                    ? P_MIN[PERIOD_W-1:0]
                    : r_period - P_STEP[PERIOD_W-1:0];

    // Next mode/pause/period from this cycle's events, B wins over all.
    always_comb begin
        w_mode_nx   = r_mode;
        w_paused_nx = r_paused;
        w_period_nx = r_period;
        if (w_ev[K_B]) begin
            w_mode_nx   = MODE_OFF;
            w_paused_nx = 1'b0;
            w_period_nx = P_DEF;
        end else begin
            if (w_ev[K_A])
                w_paused_nx = ~r_paused;
            else if (w_ev[K_RIGHT] && !w_ev[K_LEFT])
                w_mode_nx = mode_next(r_mode);
            else if (w_ev[K_LEFT] && !w_ev[K_RIGHT])
                w_mode_nx = mode_prev(r_mode);
            if (w_ev[K_UP] && !w_ev[K_DOWN])
                w_period_nx = w_per_up;
            else if (w_ev[K_DOWN] && !w_ev[K_UP])
                w_period_nx = w_per_dn;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode   <= MODE_OFF;
            r_paused <= 1'b0;
            r_period <= P_DEF;
        end else begin
            r_mode   <= w_mode_nx;
            r_paused <= w_paused_nx;
            r_period <= w_period_nx;
        end
    end

    assign w_enter_alt = (w_mode_nx == MODE_ALT) && (r_mode != MODE_ALT);
    assign w_alt_wrap  = r_alt_cnt >= (r_period - PERIOD_W'(1));

    // ALT timer: restart on entry, run while in ALT and unpaused.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_alt_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (w_enter_alt) begin
            r_alt_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (r_mode == MODE_ALT && !r_paused) begin
            if (w_alt_wrap) begin
                r_alt_cnt <= '0;
                r_phase   <= ~r_phase;
            end else begin
                r_alt_cnt <= r_alt_cnt + 1'b1;
            end
        end
    end

    // Channel enable decode from mode, pause and ALT phase.
    always_comb begin
        en1_o = 1'b0;
        en2_o = 1'b0;
        if (!r_paused) begin
            case (r_mode)
                MODE_CH1:  en1_o = 1'b1;
                MODE_CH2:  en2_o = 1'b1;
                MODE_BOTH: begin
                    en1_o = 1'b1;
                    en2_o = 1'b1;
                end
                MODE_ALT: begin
                    en1_o = ~r_phase;
                    en2_o = r_phase;
                end
                default: begin
                    en1_o = 1'b0;
                    en2_o = 1'b0;
                end
            endcase
        end
    end

    assign period_o = r_period;
    assign mode_o   = r_mode;
    assign paused_o = r_paused;

endmodule

// File: tb/tb_gamepad_ctrl.sv
// Bench for gamepad_ctrl: cycle model compared every cycle plus
// directed literal checks on latency, ALT phases and saturation.
module tb_gamepad_ctrl;

    localparam int DB = 4;
    localparam int KU = 0, KD = 1, KL = 2, KR = 3, KA = 4, KB = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] keys = '0;
    logic       en1_o, en2_o, paused_o;
    logic [7:0] period_o;
    logic [2:0] mode_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gamepad_ctrl dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .key_up_i   (keys[KU]),
        .key_down_i (keys[KD]),
        .key_left_i (keys[KL]),
        .key_right_i(keys[KR]),
        .key_a_i    (keys[KA]),
        .key_b_i    (keys[KB]),
        .en1_o      (en1_o),
        .en2_o      (en2_o),
        .period_o   (period_o),
        .mode_o     (mode_o),
        .paused_o   (paused_o)
    );

    // Model state (mode as 0..4 ring index, period as plain int).
    int         m_mode, m_per, m_cnt;
    bit         m_pau, m_ph, m_valid = 1'b0;
    int         m_run[6];
    logic [5:0] m_acc, m_ev, m_prev;

    always @(posedge clk) begin : mdl
        int  nm, np, nc;
        bit  npa, nph;
        int  tr[6];
        logic [5:0] na, ne;
        if (rst) begin
            m_mode <= 0; m_per <= 20; m_pau <= 1'b0;
            m_cnt <= 0; m_ph <= 1'b0;
            m_acc <= '0; m_ev <= '0; m_prev <= '0;
            for (int k = 0; k < 6; k++) tr[k] = 0;
            m_run <= tr;
            m_valid <= 1'b1;
        end else begin
            nm = m_mode; np = m_per; npa = m_pau;
            if (m_ev[KB]) begin
                nm = 0; np = 20; npa = 1'b0;
            end else begin
                if (m_ev[KA]) npa = !m_pau;
                else if (m_ev[KL] && !m_ev[KR]) nm = (m_mode + 4) % 5;
                else if (m_ev[KR] && !m_ev[KL]) nm = (m_mode + 1) % 5;
                if (m_ev[KU] && !m_ev[KD])
                    np = (m_per + 2 > 200) ? 200 : m_per + 2;
                else if (m_ev[KD] && !m_ev[KU])
                    np = (m_per - 2 < 2) ? 2 : m_per - 2;
            end
            nc = m_cnt; nph = m_ph;
            if (nm == 4 && m_mode != 4) begin
                nc = 0; nph = 1'b0;
            end else if (m_mode == 4 && !m_pau) begin
                if (m_cnt >= m_per - 1) begin
                    nc = 0; nph = !m_ph;
                end else nc = m_cnt + 1;
            end
            na = m_acc;
            for (int k = 0; k < 6; k++) begin
                tr[k] = (m_run[k] != 0 && keys[k] == m_prev[k])
                      ? m_run[k] + 1 : 1;
                if (tr[k] >= DB && keys[k] != m_acc[k]) na[k] = keys[k];
            end
            ne = na & ~m_acc;
            m_mode <= nm; m_per <= np; m_pau <= npa;
            m_cnt <= nc; m_ph <= nph;
            m_acc <= na; m_ev <= ne; m_prev <= keys;
            m_run <= tr;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin : cmp
        bit e1, e2;
        if (m_valid) begin
            e1 = !m_pau && (m_mode == 1 || m_mode == 3 ||
                            (m_mode == 4 && !m_ph));
            e2 = !m_pau && (m_mode == 2 || m_mode == 3 ||
                            (m_mode == 4 && m_ph));
            n_chk++;
            if (int'(mode_o) != m_mode || int'(period_o) != m_per ||
                paused_o !== m_pau || en1_o !== e1 || en2_o !== e2) begin
                n_err++;
                $display("FAIL model t=%0t got m=%0d p=%0d pa=%b e=%b%b exp m=%0d p=%0d pa=%b e=%b%b",
                         $time, mode_o, period_o, paused_o, en1_o, en2_o,
                         m_mode, m_per, m_pau, e1, e2);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic press(input int k);
        keys[k] = 1'b1;
        repeat (DB + 1) @(negedge clk);
        keys[k] = 1'b0;
        repeat (DB + 1) @(negedge clk);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_en1"}, int'(en1_o), 0);
        chk({nm, "_en2"}, int'(en2_o), 0);
        chk({nm, "_mode"}, int'(mode_o), 0);
        chk({nm, "_period"}, int'(period_o), 20);
        chk({nm, "_paused"}, int'(paused_o), 0);
    endtask

    task automatic count_hi(input bit ch, output int n);
        n = 0;
        while ((ch ? en2_o : en1_o) && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset("reset");

        keys[KR] = 1'b1;
        repeat (DB) @(negedge clk);
        chk("right_lat_early", int'(mode_o), 0);
        @(negedge clk);
        chk("right_lat_mode", int'(mode_o), 1);
        chk("right_lat_en", int'({en1_o, en2_o}), 2);
        keys[KR] = 1'b0;
        repeat (DB + 2) @(negedge clk);

        keys[KR] = 1'b1;
        repeat (DB - 1) @(negedge clk);
        keys[KR] = 1'b0;
        repeat (DB + 4) @(negedge clk);
        chk("glitch", int'(mode_o), 1);

        press(KB);
        chk("b_off", int'(mode_o), 0);
        for (int i = 1; i <= 5; i++) begin
            press(KR);
            chk("right_seq", int'(mode_o), i % 5);
        end
        press(KL);
        chk("left_wrap", int'(mode_o), 4);

        press(KB);
        keys[KL] = 1'b1;
        repeat (DB + 1) @(negedge clk);
        keys[KL] = 1'b0;
        chk("alt_enter", int'(mode_o), 4);
        count_hi(1'b0, n);
        chk("alt_ph0_len", n, 20);
        count_hi(1'b1, n);
        chk("alt_ph1_len", n, 20);

        repeat (7) @(negedge clk);
        keys[KA] = 1'b1;
        repeat (DB + 1) @(negedge clk);
        keys[KA] = 1'b0;
        chk("pause_flag", int'(paused_o), 1);
        chk("pause_en", int'({en1_o, en2_o}), 0);
        repeat (20) @(negedge clk);
        chk("pause_hold", int'({en1_o, en2_o}), 0);
        keys[KA] = 1'b1;
        repeat (DB + 1) @(negedge clk);
        keys[KA] = 1'b0;
        chk("resume_flag", int'(paused_o), 0);
        count_hi(1'b0, n);
        chk("resume_rest", n, 8);
        chk("resume_next", int'(en2_o), 1);

        keys[KA] = 1'b1;
        repeat (DB + 1) @(negedge clk);
        keys[KA] = 1'b0;
        repeat (6) @(negedge clk);
        chk("pause2", int'(paused_o), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("midrst");

        for (int i = 0; i < 100; i++) press(KU);
        chk("sat_max", int'(period_o), 200);
        for (int i = 0; i < 100; i++) press(KD);
        chk("sat_min", int'(period_o), 2);
        press(KB);
        keys[KU] = 1'b1; keys[KD] = 1'b1;
        repeat (DB + 1) @(negedge clk);
        keys[KU] = 1'b0; keys[KD] = 1'b0;
        repeat (DB + 1) @(negedge clk);
        chk("up_down", int'(period_o), 20);

        press(KR);
        press(KU);
        chk("pre_abr_per", int'(period_o), 22);
        keys[KA] = 1'b1; keys[KB] = 1'b1; keys[KR] = 1'b1;
        repeat (DB + 1) @(negedge clk);
        keys = '0;
        chk("abr_mode", int'(mode_o), 0);
        chk("abr_paused", int'(paused_o), 0);
        chk("abr_period", int'(period_o), 20);
        repeat (DB + 2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
